// File: rtl/tt_ternary_pkg.sv
// Shared definitions for the ternary matrix-vector engine: weight codes, FSM states and
// the flat weight-vector addressing helper.
package tt_ternary_pkg;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain
    } state_t;

    // Bit offset of weight (row i, column o) inside the loader's flat vector.
    function automatic int unsigned w_off(input int unsigned i, input int unsigned o,
                                          input int unsigned out_len, input int unsigned width);
        return i * out_len * width + o * width;
    endfunction

endpackage

// File: rtl/tt_ternary_pe.sv
// One output-column accumulator: adds +x, -x or 0 per ternary weight, or loads the first
// contribution of a vector directly.
module tt_ternary_pe
    import tt_ternary_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned ACC_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           weight,
    input  logic [IN_WIDTH-1:0]  data,
    input  logic                 load,
    input  logic                 en,
    output logic [ACC_WIDTH-1:0] acc
);

    logic [ACC_WIDTH-1:0] x_ext;
    logic [ACC_WIDTH-1:0] contrib;

    always_comb begin
        x_ext = {{(ACC_WIDTH - IN_WIDTH){data[IN_WIDTH-1]}}, data};
    end

    // Codes 00 and 10 both contribute zero.
    always_comb begin
        contrib = '0;
        case (weight)
            W_POS:   contrib = x_ext;
            W_NEG:   contrib = -x_ext;
            default: contrib = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= load ? contrib : acc + contrib;
        end
    end

endmodule

// File: rtl/tt_um_mult.sv
// Ternary matrix-vector engine: accepts 16 signed activations, accumulates 8 ternary dot
// products in parallel, then drains the results as a valid/ready stream.
module tt_um_mult
    import tt_ternary_pkg::*;
#(
    parameter int unsigned MAX_IN_LEN  = 16,
    parameter int unsigned MAX_OUT_LEN = 8,
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned IN_WIDTH    = 8,
    parameter int unsigned ACC_WIDTH   = IN_WIDTH + $clog2(MAX_IN_LEN) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ena,
    input  logic                                  clr,
    input  logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0] ui_weights,
    input  logic [IN_WIDTH-1:0]                   in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [ACC_WIDTH-1:0]                  out_data,
    output logic [$clog2(MAX_OUT_LEN)-1:0]        out_idx,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy
);

    localparam int unsigned CNT_W = $clog2(MAX_IN_LEN);
    localparam int unsigned OI_W  = $clog2(MAX_OUT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_IN_LEN - 1);
    localparam logic [OI_W-1:0]  OI_LAST  = OI_W'(MAX_OUT_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [OI_W-1:0]      oi;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 acc_load;
    logic [ACC_WIDTH-1:0] acc [MAX_OUT_LEN];

    always_comb begin
        in_ready  = ena && !clr && (state != StDrain);
        out_valid = (state == StDrain) && !clr;
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
        busy      = (state != StIdle);
        acc_load  = (cnt == '0);
        out_idx   = oi;
        out_data  = acc[oi];
    end

    for (genvar o = 0; o < MAX_OUT_LEN; o++) begin : g_col
        logic [WIDTH-1:0] w;

        // Row mux: the weight row follows the element counter.
        always_comb begin
            w = ui_weights[w_off(32'(cnt), o, MAX_OUT_LEN, WIDTH) +: WIDTH];
        end

        tt_ternary_pe #(
            .IN_WIDTH  (IN_WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_pe (
            .clk    (clk),
            .rst_n  (rst_n),
            .weight (w),
            .data   (in_data),
            .load   (acc_load),
            .en     (in_xfer),
            .acc    (acc[o])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            cnt   <= '0;
            oi    <= '0;
        end else if (clr) begin
            state <= StIdle;
            cnt   <= '0;
            oi    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_xfer) begin
                        state <= StAccum;
                        cnt   <= CNT_W'(1);
                    end
                end
                StAccum: begin
                    if (in_xfer) begin
                        if (cnt == CNT_LAST) begin
                            state <= StDrain;
                            cnt   <= '0;
                            oi    <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (out_xfer) begin
                        if (oi == OI_LAST) begin
                            state <= StIdle;
                            oi    <= '0;
                        end else begin
                            oi <= oi + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
